// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit carry chain is cut into STAGES slices of SLICE bits. Each stage
// adds its own slice using the carry registered by the previous stage. The
// completed low result bits, the operands still needed by later slices and the
// slice carry-out travel down the pipe together.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   STAGES  number of pipeline stages (>= 1, must divide WIDTH)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set presented
//   in_ready   operand set accepted this cycle when in_valid is also high
//   a, b       operands
//   cin        carry-in (borrow-in when sub=1)
//   sub        0 = a+b+cin, 1 = a-b-cin
//   out_valid  result presented
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   couts      per-bit ripple carry, bit i = carry out of bit i
//   cout       carry out of the MSB
//   ovf        two's-complement signed overflow

module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] couts,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    // Everything one stage hands to the next. b is already the effective
    // (possibly inverted) operand; carry is the carry into the next slice.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] couts;
        logic             carry;
    } stage_t;

    stage_t             head;
    stage_t             stg_d [STAGES];
    stage_t             stg_q [STAGES];
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  adv;
    logic [STAGES-1:0]  load;

    // Ripple-add slice k of src, starting from src.carry.
    function automatic stage_t add_slice(input stage_t src, input int k);
        stage_t res;
        logic   c;
        logic   p;
        int     idx;
        res = src;
        c   = src.carry;
        for (int i = 0; i < SLICE; i++) begin
            idx            = k * SLICE + i;
            p              = src.a[idx] ^ src.b[idx];
            res.sum[idx]   = p ^ c;
            c              = (src.a[idx] & src.b[idx]) | (p & c);
            res.couts[idx] = c;
        end
        res.carry = c;
        return res;
    endfunction

    // Subtraction is a + ~b + ~cin: with cin=0 that is the usual +1 of two's
    // complement, with cin=1 the extra borrow cancels it.
    always_comb begin
        head.a     = a;
        head.b     = sub ? ~b : b;
        head.sum   = '0;
        head.couts = '0;
        head.carry = sub ? ~cin : cin;
    end

    always_comb begin
        stg_d[0] = add_slice(head, 0);
        for (int k = 1; k < STAGES; k++) begin
            stg_d[k] = add_slice(stg_q[k-1], k);
        end
    end

    // A stage advances when it is valid and some stage above it is empty, or
    // the whole tail is full and the output is being taken. Computing this
    // top-down as a running "room above" flag collapses bubbles even while
    // the last stage is stalled.
    always_comb begin
        logic room;
        adv  = '0;
        load = '0;
        room = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] & room;
            room   = room | ~valid_q[k];
        end
        in_ready = ~rst & (~valid_q[0] | adv[0]);
        load[0]  = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                    stg_q[k]   <= stg_d[k];
                end else if (adv[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // The last stage only reloads when it is empty or being consumed, so the
    // outputs hold steady through a downstream stall.
    assign out_valid = valid_q[STAGES-1];
    assign sum       = stg_q[STAGES-1].sum;
    assign couts     = stg_q[STAGES-1].couts;
    assign cout      = stg_q[STAGES-1].couts[WIDTH-1];
    assign ovf       = stg_q[STAGES-1].couts[WIDTH-1] ^ stg_q[STAGES-1].couts[WIDTH-2];

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder.
// Three instances: 32/4 (directed, stream, stall and reset scenarios),
// 16/1 and 8/8 (latency check then random traffic with random out_ready).
// Expected results come from plain integer arithmetic in model().

module tb_pipe_adder;

    localparam int NI = 3;
    localparam int W_OF [NI] = '{32, 16, 8};
    localparam int S_OF [NI] = '{4, 1, 8};

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] couts;
        logic        cout;
        logic        ovf;
        int          acc;
        logic        lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NI-1:0] in_valid_x;
    logic [NI-1:0] out_ready_x;
    logic [NI-1:0] cin_x;
    logic [NI-1:0] sub_x;
    logic [31:0]   a_x [NI];
    logic [31:0]   b_x [NI];

    logic [NI-1:0] in_ready_x;
    logic [NI-1:0] out_valid_x;
    logic [NI-1:0] cout_x;
    logic [NI-1:0] ovf_x;
    logic [31:0]   sum_x [NI];
    logic [31:0]   couts_x [NI];

    logic [31:0] sum0, couts0;
    logic [15:0] sum1, couts1;
    logic [7:0]  sum2, couts2;

    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic [NI-1:0] lat_on;
    int            n_out [NI];
    int            n_acc [NI];
    int            pend  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipe_adder #(.WIDTH(32), .STAGES(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x[0]), .in_ready(in_ready_x[0]),
        .a(a_x[0]), .b(b_x[0]), .cin(cin_x[0]), .sub(sub_x[0]),
        .out_valid(out_valid_x[0]), .out_ready(out_ready_x[0]),
        .sum(sum0), .couts(couts0), .cout(cout_x[0]), .ovf(ovf_x[0])
    );

    pipe_adder #(.WIDTH(16), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x[1]), .in_ready(in_ready_x[1]),
        .a(a_x[1][15:0]), .b(b_x[1][15:0]), .cin(cin_x[1]), .sub(sub_x[1]),
        .out_valid(out_valid_x[1]), .out_ready(out_ready_x[1]),
        .sum(sum1), .couts(couts1), .cout(cout_x[1]), .ovf(ovf_x[1])
    );

    pipe_adder #(.WIDTH(8), .STAGES(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x[2]), .in_ready(in_ready_x[2]),
        .a(a_x[2][7:0]), .b(b_x[2][7:0]), .cin(cin_x[2]), .sub(sub_x[2]),
        .out_valid(out_valid_x[2]), .out_ready(out_ready_x[2]),
        .sum(sum2), .couts(couts2), .cout(cout_x[2]), .ovf(ovf_x[2])
    );

    always_comb begin
        sum_x[0]   = sum0;
        sum_x[1]   = {16'b0, sum1};
        sum_x[2]   = {24'b0, sum2};
        couts_x[0] = couts0;
        couts_x[1] = {16'b0, couts1};
        couts_x[2] = {24'b0, couts2};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int bound);
        tests++;
        fails++;
        $display("FAIL %s timeout: got no completion, expected within %0d cycles", name, bound);
    endtask

    // Reference: a+b+cin or a-b-cin on plain integers. Carry out of bit k is
    // bit k+1 of the sum of the low k+1 bits; overflow is the signed result
    // falling outside the w-bit signed range.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic su);
        exp_t   e;
        longint m, ai, bi, be, lo, lm, sa, sb, r, half;
        logic   ce;
        e    = '0;
        m    = (longint'(1) << w) - 1;
        ai   = longint'({32'b0, av}) & m;
        bi   = longint'({32'b0, bv}) & m;
        be   = su ? (~bi & m) : bi;
        ce   = su ? ~ci : ci;
        r    = su ? ai - bi - longint'(ci) : ai + bi + longint'(ci);
        e.sum = 32'(r & m);
        for (int k = 0; k < w; k++) begin
            lm = (longint'(1) << (k + 1)) - 1;
            lo = (ai & lm) + (be & lm) + longint'(ce);
            e.couts[k] = lo[k+1];
        end
        half = longint'(1) << (w - 1);
        sa   = (ai >= half) ? ai - 2 * half : ai;
        sb   = (bi >= half) ? bi - 2 * half : bi;
        r    = su ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
        e.ovf  = (r >= half) || (r < -half);
        e.cout = e.couts[w-1];
        return e;
    endfunction

    // Per-instance scoreboard: push on input handshake, pop and compare on
    // output handshake, check hold during stalls, flush on reset.
    for (genvar g = 0; g < NI; g++) begin : g_mon
        localparam int W = W_OF[g];
        localparam int S = S_OF[g];
        exp_t        sb [$];
        logic        prev_stall = 1'b0;
        logic [31:0] prev_sum, prev_couts;
        logic        prev_ovf;

        always @(negedge clk or posedge rst) begin
            exp_t e;
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
                pend[g]    = 0;
            end else begin
                if (prev_stall) begin
                    check($sformatf("u%0d hold out_valid", g), 32'(out_valid_x[g]), 32'd1);
                    check($sformatf("u%0d hold sum", g), sum_x[g], prev_sum);
                    check($sformatf("u%0d hold couts", g), couts_x[g], prev_couts);
                    check($sformatf("u%0d hold ovf", g), 32'(ovf_x[g]), 32'(prev_ovf));
                end
                if (out_valid_x[g] && out_ready_x[g]) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL u%0d unexpected output: got sum 0x%0h, expected no output", g, sum_x[g]);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("u%0d sum", g), sum_x[g], e.sum);
                        check($sformatf("u%0d couts", g), couts_x[g], e.couts);
                        check($sformatf("u%0d cout", g), 32'(cout_x[g]), 32'(e.cout));
                        check($sformatf("u%0d ovf", g), 32'(ovf_x[g]), 32'(e.ovf));
                        if (e.lat)
                            check($sformatf("u%0d latency", g), 32'(cyc - e.acc), 32'(S));
                        n_out[g]++;
                    end
                end
                prev_stall = out_valid_x[g] && !out_ready_x[g];
                prev_sum   = sum_x[g];
                prev_couts = couts_x[g];
                prev_ovf   = ovf_x[g];
                if (in_valid_x[g] && in_ready_x[g]) begin
                    e     = model(W, a_x[g], b_x[g], cin_x[g], sub_x[g]);
                    e.acc = cyc;
                    e.lat = lat_on[g];
                    sb.push_back(e);
                    n_acc[g]++;
                end
                pend[g] = sb.size();
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int i, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic su, output int waited);
        int c;
        c = 0;
        a_x[i] = av;
        b_x[i] = bv;
        cin_x[i] = ci;
        sub_x[i] = su;
        in_valid_x[i] = 1'b1;
        @(negedge clk);
        while (!in_ready_x[i] && c < 200) begin
            c++;
            @(negedge clk);
        end
        if (!in_ready_x[i]) timeout_fail($sformatf("u%0d accept", i), 200);
        @(posedge clk);
        #1;
        in_valid_x[i] = 1'b0;
        waited = c;
    endtask

    task automatic wait_drain(input int i, input int bound);
        int c;
        c = 0;
        while (pend[i] != 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        if (pend[i] != 0) timeout_fail($sformatf("u%0d drain", i), bound);
        @(posedge clk);
        #1;
    endtask

    // Directed case on u0 with exact-latency check of out_valid.
    task automatic direct(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic su,
                          input logic [31:0] es, input logic ec, input logic eo);
        int w;
        issue(0, av, bv, ci, su, w);
        for (int j = 1; j < S_OF[0]; j++) begin
            @(negedge clk);
            check({nm, " early out_valid"}, 32'(out_valid_x[0]), 32'd0);
        end
        @(negedge clk);
        check({nm, " out_valid"}, 32'(out_valid_x[0]), 32'd1);
        check({nm, " sum"}, sum_x[0], es);
        check({nm, " cout"}, 32'(cout_x[0]), 32'(ec));
        check({nm, " ovf"}, 32'(ovf_x[0]), 32'(eo));
    endtask

    task automatic run_random(input int i, input int n);
        int   w, got, cycles;
        logic acc;
        lat_on[i] = 1'b1;
        out_ready_x[i] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        wait_drain(i, 60);
        lat_on[i] = 1'b0;
        got = 0;
        cycles = 0;
        a_x[i] = $urandom;
        b_x[i] = $urandom;
        cin_x[i] = 1'($urandom_range(0, 1));
        sub_x[i] = 1'($urandom_range(0, 1));
        in_valid_x[i] = ($urandom_range(0, 3) != 0);
        while (got < n && cycles < n * 30) begin
            @(negedge clk);
            acc = in_valid_x[i] && in_ready_x[i];
            if (acc) got++;
            @(posedge clk);
            #1;
            cycles++;
            out_ready_x[i] = ($urandom_range(0, 2) != 0);
            if (acc || !in_valid_x[i]) begin
                a_x[i] = $urandom;
                b_x[i] = $urandom;
                cin_x[i] = 1'($urandom_range(0, 1));
                sub_x[i] = 1'($urandom_range(0, 1));
                in_valid_x[i] = ($urandom_range(0, 3) != 0);
            end
        end
        if (got < n) timeout_fail($sformatf("u%0d random stream", i), n * 30);
        in_valid_x[i] = 1'b0;
        out_ready_x[i] = 1'b1;
        wait_drain(i, 200);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, acc_cnt, base;
        logic        got, have;
        logic [31:0] held;

        in_valid_x  = '0;
        out_ready_x = '1;
        cin_x       = '0;
        sub_x       = '0;
        lat_on      = '0;
        for (int i = 0; i < NI; i++) begin
            a_x[i] = '0;
            b_x[i] = '0;
            n_out[i] = 0;
            n_acc[i] = 0;
            pend[i] = 0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d rst out_valid", i), 32'(out_valid_x[i]), 32'd0);
            check($sformatf("u%0d rst in_ready", i), 32'(in_ready_x[i]), 32'd0);
            check($sformatf("u%0d rst sum", i), sum_x[i], 32'd0);
            check($sformatf("u%0d rst couts", i), couts_x[i], 32'd0);
            check($sformatf("u%0d rst cout", i), 32'(cout_x[i]), 32'd0);
            check($sformatf("u%0d rst ovf", i), 32'(ovf_x[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("u%0d in_ready after reset", i), 32'(in_ready_x[i]), 32'd1);
        @(posedge clk);
        #1;

        // Directed corner cases on u0
        lat_on[0] = 1'b1;
        direct("carry ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("carry ripple couts", couts_x[0], 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        direct("signed ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        direct("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        direct("sub borrow", 32'd9, 32'd3, 1'b1, 1'b1, 32'd5, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        wait_drain(0, 20);

        // Back-to-back random stream, one per cycle
        for (int n = 0; n < 100; n++) begin
            issue(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            check("stream in_ready", 32'(w), 32'd0);
        end
        wait_drain(0, 40);
        lat_on[0] = 1'b0;

        // Downstream stall with continuous input
        out_ready_x[0] = 1'b0;
        a_x[0] = $urandom;
        b_x[0] = $urandom;
        sub_x[0] = 1'($urandom_range(0, 1));
        cin_x[0] = 1'($urandom_range(0, 1));
        in_valid_x[0] = 1'b1;
        acc_cnt = 0;
        have = 1'b0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            got = in_ready_x[0];
            if (got) acc_cnt++;
            if (out_valid_x[0] && !have) begin
                held = sum_x[0];
                have = 1'b1;
            end
            @(posedge clk);
            #1;
            if (got) begin
                a_x[0] = $urandom;
                b_x[0] = $urandom;
                sub_x[0] = 1'($urandom_range(0, 1));
                cin_x[0] = 1'($urandom_range(0, 1));
            end
        end
        check("stall accepted count", 32'(acc_cnt), 32'(S_OF[0]));
        @(negedge clk);
        check("stall in_ready", 32'(in_ready_x[0]), 32'd0);
        check("stall out_valid", 32'(out_valid_x[0]), 32'd1);
        check("stall sum constant", sum_x[0], held);
        @(posedge clk);
        #1;
        in_valid_x[0] = 1'b0;
        out_ready_x[0] = 1'b1;
        wait_drain(0, 40);

        // Reset with three transactions in flight, mid-cycle, while stalled
        out_ready_x[0] = 1'b0;
        for (int k = 0; k < 3; k++)
            issue(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        begin
            int c;
            c = 0;
            @(negedge clk);
            while (!out_valid_x[0] && c < 10) begin
                c++;
                @(negedge clk);
            end
            if (!out_valid_x[0]) timeout_fail("in-flight out_valid", 10);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid_x[0]), 32'd0);
        check("async rst in_ready", 32'(in_ready_x[0]), 32'd0);
        check("async rst sum", sum_x[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready_x[0] = 1'b1;
        base = n_out[0];
        @(negedge clk);
        check("in_ready after mid reset", 32'(in_ready_x[0]), 32'd1);
        repeat (10) @(negedge clk);
        check("no stale output count", 32'(n_out[0]), 32'(base));
        check("no stale out_valid", 32'(out_valid_x[0]), 32'd0);
        @(posedge clk);
        #1;

        // Other geometries with random backpressure
        fork
            run_random(1, 150);
            run_random(2, 150);
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
